// File: rtl/branch_predict_unit.sv
// Decode-stage branch resolver with a 2-bit PHT predictor, registered redirect
// and saturating branch/mispredict statistics.

module bpu_pht_entry #(
  parameter logic [1:0] INIT_ST = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_i,
  input  logic       taken_i,
  output logic [1:0] st_o
);
  logic [1:0] st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (upd_i) begin
      if (taken_i && st_q != 2'b11)       st_d = st_q + 2'd1;
      else if (!taken_i && st_q != 2'b00) st_d = st_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= INIT_ST;
    else     st_q <= st_d;
  end

  assign st_o = st_q;
endmodule

module branch_predict_unit #(
  parameter int         DATA_W  = 32,
  parameter int         IDX_W   = 6,
  parameter int         CNT_W   = 32,
  parameter logic [1:0] INIT_ST = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [5:0]        res_op,
  input  logic [4:0]        res_rt,
  input  logic [DATA_W-1:0] res_a,
  input  logic [DATA_W-1:0] res_b,
  input  logic              res_pred_taken,
  input  logic [31:0]       res_target,
  output logic              is_branch,
  output logic              actual_taken,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][1:0] pht_st;
  logic [IDX_W-1:0]      pred_idx, res_idx;
  logic                  rec, cond, a_neg, a_zero, upd, mis_now;
  logic                  unused_pc_bits;

  logic              is_branch_q, is_branch_d;
  logic              actual_taken_q, actual_taken_d;
  logic              mispredict_q, mispredict_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  assign pred_idx       = pred_pc[IDX_W+1:2];
  assign res_idx        = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign a_neg  = res_a[DATA_W-1];
  assign a_zero = (res_a == '0);

  always_comb begin
    rec  = 1'b1;
    cond = 1'b0;
    unique case (res_op)
      6'b000100: cond = (res_a == res_b);
      6'b000101: cond = (res_a != res_b);
      6'b000111: cond = !a_neg && !a_zero;
      6'b000110: cond = a_neg || a_zero;
      6'b000001: begin
        // REGIMM: bit 4 of rt only selects the linking variant
        if (res_rt[3:0] == 4'b0001)      cond = !a_neg;
        else if (res_rt[3:0] == 4'b0000) cond = a_neg;
        else                             rec  = 1'b0;
      end
      default:   rec = 1'b0;
    endcase
    if (!rec) cond = 1'b0;
  end

  // Link-bit form must still have rt[4] as 0 or 1 only; rt[3:0] decode above
  // covers 00000/10000 and 00001/10001 exactly.
  assign upd     = res_valid && rec;
  assign mis_now = upd && (cond != res_pred_taken);

  for (genvar g = 0; g < DEPTH; g++) begin : g_pht
    bpu_pht_entry #(.INIT_ST(INIT_ST)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .upd_i   (upd && (res_idx == IDX_W'(g))),
      .taken_i (cond),
      .st_o    (pht_st[g])
    );
  end

  // Read is from registered state, so a same-cycle update is not bypassed.
  assign pred_taken = pht_st[pred_idx][1];

  always_comb begin
    is_branch_d    = 1'b0;
    actual_taken_d = actual_taken_q;
    mispredict_d   = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    branch_cnt_d   = branch_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if (res_valid) begin
      is_branch_d    = rec;
      actual_taken_d = cond;
      mispredict_d   = mis_now;
      if (rec) redirect_pc_d = cond ? res_target : res_pc + 32'd8;
    end
    if (upd && branch_cnt_q != '1)     branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mis_now && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
    if (clear_stats) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_branch_q    <= 1'b0;
      actual_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      branch_cnt_q   <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      is_branch_q    <= is_branch_d;
      actual_taken_q <= actual_taken_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      branch_cnt_q   <= branch_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign is_branch    = is_branch_q;
  assign actual_taken = actual_taken_q;
  assign mispredict   = mispredict_q;
  assign redirect_pc  = redirect_pc_q;
  assign branch_cnt   = branch_cnt_q;
  assign mispred_cnt  = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized check of branch_predict_unit against a behavioural
// model (signed compares, PHT as an int array, saturating int counters).

module tb_branch_predict_unit;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 3;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       pred_pc = '0;
  logic              pred_taken;
  logic              res_valid = 1'b0;
  logic [31:0]       res_pc = '0;
  logic [5:0]        res_op = '0;
  logic [4:0]        res_rt = '0;
  logic [DATA_W-1:0] res_a = '0, res_b = '0;
  logic              res_pred_taken = 1'b0;
  logic [31:0]       res_target = '0;
  logic              is_branch, actual_taken, mispredict;
  logic [31:0]       redirect_pc;
  logic              clear_stats = 1'b0;
  logic [CNT_W-1:0]  branch_cnt, mispred_cnt;

  branch_predict_unit #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_ST(2'b01)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_op(res_op), .res_rt(res_rt),
    .res_a(res_a), .res_b(res_b), .res_pred_taken(res_pred_taken), .res_target(res_target),
    .is_branch(is_branch), .actual_taken(actual_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .clear_stats(clear_stats),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  int          m_pht [DEPTH];
  bit          m_isb, m_act, m_mis;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_isb = 0; m_act = 0; m_mis = 0; m_rpc = '0; m_bc = 0; m_mc = 0;
  endtask

  task automatic ref_cond(output bit rec, output bit cond);
    int sa;
    sa = $signed(res_a);
    rec = 1; cond = 0;
    case (res_op)
      6'd4: cond = (res_a == res_b);
      6'd5: cond = (res_a != res_b);
      6'd7: cond = (sa > 0);
      6'd6: cond = (sa <= 0);
      6'd1: begin
        if (res_rt == 5'd1 || res_rt == 5'd17)      cond = (sa >= 0);
        else if (res_rt == 5'd0 || res_rt == 5'd16) cond = (sa < 0);
        else rec = 0;
      end
      default: rec = 0;
    endcase
  endtask

  task automatic model_edge();
    bit rec, cond;
    int i;
    ref_cond(rec, cond);
    if (res_valid) begin
      m_isb = rec;
      m_act = rec && cond;
      m_mis = rec && (cond != res_pred_taken);
      if (rec) begin
        m_rpc = cond ? res_target : res_pc + 32'd8;
        i = idx_of(res_pc);
        m_pht[i] = cond ? ((m_pht[i] < 3) ? m_pht[i] + 1 : 3) : ((m_pht[i] > 0) ? m_pht[i] - 1 : 0);
        if (m_bc < CMAX) m_bc++;
        if (m_mis && m_mc < CMAX) m_mc++;
      end
    end else begin
      m_isb = 0; m_mis = 0;
    end
    if (clear_stats) begin m_bc = 0; m_mc = 0; end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".isb"}, is_branch, m_isb);
    chk({tag, ".act"}, actual_taken, m_act);
    chk({tag, ".mis"}, mispredict, m_mis);
    chk({tag, ".rpc"}, redirect_pc, m_rpc);
    chk({tag, ".bc"}, branch_cnt, m_bc);
    chk({tag, ".mc"}, mispred_cnt, m_mc);
  endtask

  // Inputs set at posedge+1; checks prediction pre-edge, registered outputs after.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".pred"}, pred_taken, m_pht[idx_of(pred_pc)] >= 2);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic br(input string tag, input logic [5:0] op, input logic [4:0] rt,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                    input bit pt, input logic [31:0] tgt);
    res_valid = 1; res_op = op; res_rt = rt; res_a = a; res_b = b;
    res_pc = pc; res_pred_taken = pt; res_target = tgt; pred_pc = pc;
    cycle(tag);
    res_valid = 0;
  endtask

  initial begin
    logic [5:0]  ops [7];
    logic [4:0]  rts [5];
    logic [31:0] pcs [4];
    ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd6; ops[3] = 6'd7;
    ops[4] = 6'd1; ops[5] = 6'd35; ops[6] = 6'd0;
    rts[0] = 5'd0; rts[1] = 5'd1; rts[2] = 5'd16; rts[3] = 5'd17; rts[4] = 5'd3;
    pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0020; pcs[2] = 32'h0040_0110; pcs[3] = 32'h0040_00FC;

    // 1: reset state, every index weakly not-taken
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst");
    for (int i = 0; i < DEPTH; i++) begin
      pred_pc = 32'h0040_0000 | (32'(i) << 2);
      #1 chk("rst.pht", pred_taken, 1'b0);
    end
    rst = 0;
    pred_pc = 32'h0040_0010;

    // 2: BEQ taken, predicted not taken
    br("beq", 6'd4, 5'd0, 32'h5, 32'h5, 32'h0040_0010, 0, 32'h0040_0100);
    chk("beq.act_c", actual_taken, 1'b1);
    chk("beq.mis_c", mispredict, 1'b1);
    chk("beq.rpc_c", redirect_pc, 32'h0040_0100);
    chk("beq.bc_c", branch_cnt, 3'd1);
    pred_pc = 32'h0040_0010;
    cycle("idle");
    chk("beq.pulse", mispredict, 1'b0);
    chk("beq.pred_c", pred_taken, 1'b1);

    // 3: BGTZ on most-negative, BLEZ on zero
    br("bgtz", 6'd7, 5'd0, 32'h8000_0000, 32'h0, 32'h0040_0040, 0, 32'h0040_0400);
    chk("bgtz.rpc_c", redirect_pc, 32'h0040_0048);
    chk("bgtz.act_c", actual_taken, 1'b0);
    br("blez", 6'd6, 5'd0, 32'h0, 32'h0, 32'h0040_0044, 1, 32'h0040_0500);
    chk("blez.rpc_c", redirect_pc, 32'h0040_0500);
    chk("blez.mis_c", mispredict, 1'b0);

    // 4: saturate up then walk down
    for (int i = 0; i < 4; i++) br("bne_t", 6'd5, 5'd0, 32'h1, 32'h2, 32'h0040_0020, 1, 32'h0040_0800);
    pred_pc = 32'h0040_0020;
    #1 chk("bne.sat", pred_taken, 1'b1);
    for (int i = 0; i < 3; i++) br("bne_n", 6'd5, 5'd0, 32'h3, 32'h3, 32'h0040_0020, 1, 32'h0040_0800);
    pred_pc = 32'h0040_0020;
    #1 chk("bne.low", pred_taken, 1'b0);
    br("bne_0", 6'd5, 5'd0, 32'h3, 32'h3, 32'h0040_0020, 0, 32'h0040_0800);

    // 5: non-branch and not-taken BGEZAL
    br("lw", 6'b100011, 5'd0, 32'h5, 32'h5, 32'h0040_0010, 1, 32'h0040_0900);
    chk("lw.isb_c", is_branch, 1'b0);
    br("bgezal", 6'd1, 5'd17, 32'hFFFF_FFFF, 32'h0, 32'h0040_0060, 0, 32'h0040_0A00);
    chk("bgezal.act_c", actual_taken, 1'b0);

    // 6: counter saturation, clear priority, async reset
    for (int i = 0; i < 9; i++) br("sat", 6'd4, 5'd0, 32'h7, 32'h7, 32'h0040_0080, 0, 32'h0040_0B00);
    chk("sat.bc_c", branch_cnt, 3'd7);
    chk("sat.mc_c", mispred_cnt, 3'd7);
    clear_stats = 1;
    br("clr", 6'd4, 5'd0, 32'h7, 32'h7, 32'h0040_0080, 0, 32'h0040_0B00);
    clear_stats = 0;
    chk("clr.bc_c", branch_cnt, 3'd0);
    chk("clr.mc_c", mispred_cnt, 3'd0);
    br("pre_rst", 6'd4, 5'd0, 32'h7, 32'h7, 32'h0040_0080, 0, 32'h0040_0B00);
    #2 rst = 1;
    #1;
    model_reset();
    check_outs("arst");
    pred_pc = 32'h0040_0080;
    #1 chk("arst.pht", pred_taken, 1'b0);
    @(posedge clk);
    #1 rst = 0;

    // randomized traffic with aliasing PCs
    for (int n = 0; n < 400; n++) begin
      res_valid      = ($urandom_range(0, 4) != 0);
      res_op         = ops[$urandom_range(0, 6)];
      res_rt         = rts[$urandom_range(0, 4)];
      res_a          = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      res_b          = ($urandom_range(0, 2) == 0) ? res_a : $urandom;
      res_pc         = pcs[$urandom_range(0, 3)] ^ ({$urandom_range(0, 3), 24'h0, 6'h0} << 2);
      res_pred_taken = $urandom_range(0, 1);
      res_target     = $urandom & 32'hFFFF_FFFC;
      pred_pc        = pcs[$urandom_range(0, 3)] ^ (32'($urandom_range(0, 1)) << 20);
      clear_stats    = ($urandom_range(0, 30) == 0);
      cycle("rnd");
    end
    res_valid = 0; clear_stats = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
